// File: rtl/uart_tx.sv
// Byte-wide UART transmitter (8N1, no parity) fed by a small FIFO.
// The FSM pops the head byte straight into a shift register, so back-to-back frames leave no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_txd,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, have, bit_end;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd, txd_n;

  assign o_ready = (count != FULL);
  assign o_count = count;
  assign o_busy  = (state != IDLE) || (count != '0);
  assign o_txd   = txd;
  assign push    = i_valid && o_ready;
  assign have    = (count != '0);
  assign bit_end = (clk_cnt == LAST);

  // Storage carries no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    txd_n     = txd;
    clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        txd_n     = 1'b1;
        if (have) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          txd_n     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shift_n   = {1'b0, shift[7:1]};
            txd_n     = shift[1];
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_end) begin
          if (have) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a 9600-baud instance (1250 clk/bit) and a fast instance (2 clk/bit),
// both checked every cycle against a frame-position model plus literal waveform expectations.
module tb_uart_tx;
  localparam int CPB0 = 1250, CPB1 = 2, DEPTH = 4;

  typedef struct packed {
    int         cnt;
    int         head;
    logic       act;
    int         pos;
    logic [7:0] fb;
  } mdl_t;

  logic clk = 1'b0, rst = 1'b0;
  logic v0, v1;
  logic [7:0] d0, d1;
  logic rdy0, rdy1, txd0, txd1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  mdl_t m [2];
  logic [7:0] mf [2][DEPTH];

  logic [7:0] rxs [3];
  logic       rxok [3];
  bit         rx_done = 1'b0;
  logic [7:0] got [6];
  logic       gok [6];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(DEPTH)) u_slow (
    .clk(clk), .rst(rst), .i_data(d0), .i_valid(v0),
    .o_ready(rdy0), .o_txd(txd0), .o_busy(busy0), .o_count(cnt0));

  uart_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(DEPTH)) u_fast (
    .clk(clk), .rst(rst), .i_data(d1), .i_valid(v1),
    .o_ready(rdy1), .o_txd(txd1), .o_busy(busy1), .o_count(cnt1));

  // Model: a FIFO of bytes plus "which cycle of which frame is on the line".
  function automatic mdl_t step(mdl_t s, logic push, logic [7:0] head_byte, int cpb);
    mdl_t n = s;
    int pre = s.cnt;
    if (n.act) begin
      n.pos = n.pos + 1;
      if (n.pos == 10 * cpb) n.act = 1'b0;
    end
    if (!n.act && pre > 0) begin
      n.fb   = head_byte;
      n.head = (n.head + 1) % DEPTH;
      n.cnt  = n.cnt - 1;
      n.act  = 1'b1;
      n.pos  = 0;
    end
    if (push) n.cnt = n.cnt + 1;
    return n;
  endfunction

  function automatic logic exp_txd(mdl_t s, int cpb);
    int k;
    if (!s.act) return 1'b1;
    k = s.pos / cpb;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return s.fb[k-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) m[d] <= '0;
    end else begin
      m[0] <= step(m[0], v0 && m[0].cnt < DEPTH, mf[0][m[0].head], CPB0);
      m[1] <= step(m[1], v1 && m[1].cnt < DEPTH, mf[1][m[1].head], CPB1);
      if (v0 && m[0].cnt < DEPTH) mf[0][(m[0].head + m[0].cnt) % DEPTH] <= d0;
      if (v1 && m[1].cnt < DEPTH) mf[1][(m[1].head + m[1].cnt) % DEPTH] <= d1;
    end
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd0",  txd0,  exp_txd(m[0], CPB0));
      check("busy0", busy0, m[0].act || m[0].cnt != 0);
      check("cnt0",  cnt0,  m[0].cnt);
      check("rdy0",  rdy0,  m[0].cnt != DEPTH);
      check("txd1",  txd1,  exp_txd(m[1], CPB1));
      check("busy1", busy1, m[1].act || m[1].cnt != 0);
      check("cnt1",  cnt1,  m[1].cnt);
      check("rdy1",  rdy1,  m[1].cnt != DEPTH);
    end
  end

  function automatic logic line(input int sel);
    return sel != 0 ? txd1 : txd0;
  endfunction

  // Plain UART receiver: find the start edge, sample at bit centres, verify the stop bit.
  task automatic rx_frame(input int sel, input int cpb, input int tmo,
                          output logic [7:0] b, output logic ok);
    int t = 0;
    b = '0;
    ok = 1'b0;
    while (line(sel) !== 1'b0 && t < tmo) begin
      @(negedge clk);
      t++;
    end
    if (t >= tmo) return;
    repeat (cpb + cpb / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b[i] = line(sel);
      repeat (cpb) @(negedge clk);
    end
    ok = (line(sel) === 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f61, fa5;
    logic [7:0] rb1;
    logic       rok1;
    int         k, it, lows;
    bit         r, saw_full;
    f61 = 10'b1011000010;
    fa5 = 10'b1101001010;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    #1;
    check("rst_txd", txd0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_cnt", cnt0, 3'd0);
    check("rst_rdy", rdy0, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    fork
      begin
        logic [7:0] rb;
        logic       rok;
        for (int i = 0; i < 3; i++) begin
          rx_frame(0, CPB0, 20000, rb, rok);
          rxs[i] = rb;
          rxok[i] = rok;
        end
        rx_done = 1'b1;
      end
    join_none

    // Single 0x61 at 9600 baud: bit-centre levels and busy timing.
    @(negedge clk); v0 = 1'b1; d0 = 8'h61;
    @(negedge clk); v0 = 1'b0;
    repeat (626) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) repeat (CPB0) @(negedge clk);
      check($sformatf("f61_bit%0d", j), txd0, f61[j]);
    end
    repeat (624) @(negedge clk);
    check("f61_busy_end", busy0, 1'b1);
    @(negedge clk);
    check("f61_busy_low", busy0, 1'b0);
    check("f61_idle_txd", txd0, 1'b1);

    // 0x00 then 0xFF back to back: no idle gap between frames.
    @(negedge clk); v0 = 1'b1; d0 = 8'h00;
    @(negedge clk); d0 = 8'hFF;
    @(negedge clk); v0 = 1'b0;
    repeat (12499) @(negedge clk);
    check("b2b_stop1", txd0, 1'b1);
    @(negedge clk);
    check("b2b_start2", txd0, 1'b0);
    check("b2b_busy", busy0, 1'b1);
    repeat (12499) @(negedge clk);
    check("b2b_busy_end", busy0, 1'b1);
    @(negedge clk);
    check("b2b_busy_low", busy0, 1'b0);

    it = 0;
    while (!rx_done && it < 200) begin @(negedge clk); it++; end
    check("rx_done", rx_done, 1'b1);
    check("rx0", {rxok[0], rxs[0]}, {1'b1, 8'h61});
    check("rx1", {rxok[1], rxs[1]}, {1'b1, 8'h00});
    check("rx2", {rxok[2], rxs[2]}, {1'b1, 8'hFF});

    // Fast instance, 0xA5 at 2 clk/bit: every cycle of the 20-cycle frame.
    @(negedge clk); v1 = 1'b1; d1 = 8'hA5;
    @(negedge clk); v1 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check($sformatf("fa5_c%0d", j), txd1, fa5[j/2]);
    end
    @(negedge clk);
    check("fa5_busy_low", busy1, 1'b0);
    check("fa5_idle_txd", txd1, 1'b1);

    // Producer streams 0x01..0x06 with valid held high; FIFO fills and back-pressures.
    saw_full = 1'b0;
    fork
      begin
        @(negedge clk);
        v1 = 1'b1; k = 1; d1 = 8'(k); it = 0;
        while (k <= 6 && it < 500) begin
          r = rdy1;
          if (cnt1 == 3'd4 && !rdy1) saw_full = 1'b1;
          @(negedge clk);
          it++;
          if (r) begin k++; d1 = 8'(k); end
        end
        v1 = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_frame(1, CPB1, 200, rb1, rok1);
          got[i] = rb1;
          gok[i] = rok1;
        end
      end
    join
    check("stream_full", saw_full, 1'b1);
    for (int i = 0; i < 6; i++)
      check($sformatf("stream_rx%0d", i), {gok[i], got[i]}, {1'b1, 8'(i + 1)});
    repeat (5) @(negedge clk);

    // Reset in the middle of data bit 4 of 0x55 with two bytes queued.
    @(negedge clk); v1 = 1'b1; d1 = 8'h55;
    @(negedge clk); d1 = 8'h11;
    @(negedge clk); d1 = 8'h22;
    @(negedge clk); v1 = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_bit4", txd1, 1'b1);
    check("abort_cnt_pre", cnt1, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_txd", txd1, 1'b1);
    check("abort_cnt", cnt1, 3'd0);
    check("abort_busy", busy1, 1'b0);
    check("abort_rdy", rdy1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0) lows++;
    end
    check("abort_quiet", lows, 0);

    // Random producer traffic on the fast instance, model checked every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      v1 = (c % 500 < 250) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
      d1 = 8'($urandom);
    end
    @(negedge clk); v1 = 1'b0;
    repeat (300) @(negedge clk);
    check("rand_drained", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1250, meaning clk cycles per serial bit (9600 baud at 12 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning number of byte entries in the transmit FIFO; power of two, 2..16.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_data  input  8  byte to transmit, sampled when i_valid and o_ready are both high.
REQ-006 The block SHALL have port i_valid  input  1  producer offers i_data this cycle.
REQ-007 The block SHALL have port o_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port o_txd  output  1  serial line, idle high, registered.
REQ-009 The block SHALL have port o_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 The block SHALL have port o_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO, excluding the frame in flight.

Function
REQ-011 The block SHALL drive o_ready = (o_count != FIFO_DEPTH), combinationally from the registered count.
REQ-012 The block SHALL write i_data into the FIFO on every rising edge with i_valid && o_ready; i_data is ignored otherwise.
REQ-013 The block SHALL leave o_count unchanged when a push and a pop occur on the same edge, and SHALL increment or decrement it by 1 on a lone push or pop.
REQ-014 The block SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; order of bytes out SHALL equal order of bytes in.
REQ-015 The block SHALL implement FSM states IDLE, START, DATA, STOP with a bit-period counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-016 The block SHALL transition IDLE->START on the edge where the FIFO is non-empty, popping the head byte into a shift register and driving o_txd=0 from that edge.
REQ-017 The block SHALL hold each bit for exactly CLKS_PER_BIT cycles; START->DATA after one bit period with o_txd = data[0].
REQ-018 The block SHALL send data bits LSB first; DATA->STOP after bit 7's period completes, driving o_txd=1.
REQ-019 The block SHALL, at end of the stop-bit period, go STOP->START (popping the next byte, no idle gap) if the FIFO is non-empty, else STOP->IDLE.
REQ-020 The block SHALL make one frame exactly 10*CLKS_PER_BIT cycles (start, 8 data, 1 stop; no parity).
REQ-021 The block SHALL have latency of 1 cycle: a byte pushed into an empty FIFO while IDLE at edge N is popped and o_txd falls at edge N+1.
REQ-022 The block SHALL accept pushes in any FSM state, including on the pop edge of a full FIFO: o_ready rises the cycle after the pop.
REQ-023 The block SHALL keep o_txd high at all times in IDLE.

Reset
REQ-024 The block SHALL, on rst asserted, immediately set o_txd=1, FSM=IDLE, counters=0, FIFO pointers=0, o_count=0, o_busy=0, o_ready=1.
REQ-025 The block SHALL abort any frame in flight on rst mid-frame (line returns high immediately) and discard FIFO contents; no partial frame resumes after release.
REQ-026 The block SHALL begin normal operation on the first rising edge after rst deasserts.

Verification
REQ-027 The bench SHALL push 0x61 once -> o_txd reads 0,1,0,0,0,0,1,1,0,1 sampled at bit centres, each level held 1250 cycles, o_busy low 12500 cycles after push, then o_txd stays 1.
REQ-028 The bench SHALL push 0x00 and 0xFF back-to-back -> two frames contiguous (total 25000 cycles), stop bit of frame 1 followed directly by start bit of frame 2.
REQ-029 The bench SHALL hold i_valid high with bytes 0x01..0x06 during one frame (FIFO_DEPTH=4) -> o_ready low once o_count=4, first pop frees a slot, all 6 bytes appear on o_txd in order, none lost or duplicated.
REQ-030 The bench SHALL assert rst for 3 cycles mid data bit 4 of 0x55 with 2 bytes queued -> o_txd=1 within the reset, o_count=0, no further frames after release.
REQ-031 The bench SHALL run CLKS_PER_BIT=2 with 0xA5 -> frame is 20 cycles, bits 0,1,0,1,0,0,1,0,1,1.
REQ-032 The bench SHALL loop o_txd into the system's UART receive input at 9600 baud and check the received byte equals each transmitted byte for 0x00, 0x61, 0xFF.
